// File: rtl/multi_line_call_ctrl_pkg.sv
// Shared encodings for the multi-line call controller: per-line states,
// inbound event codes and outbound command codes.
package multi_line_call_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int IN_CMD_W = 4;
    localparam int OUT_CMD_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_OUTGOING = 3'd2,
        ST_INCOMING = 3'd3,
        ST_BUSY     = 3'd4,
        ST_HOLD     = 3'd5,
        ST_ENDING   = 3'd6
    } line_state_e;

    localparam logic [IN_CMD_W-1:0] IN_ENDED     = 4'd0;
    localparam logic [IN_CMD_W-1:0] IN_CONNECTED = 4'd2;
    localparam logic [IN_CMD_W-1:0] IN_INCOMING  = 4'd6;

    localparam logic [OUT_CMD_W-1:0] OUT_CALL   = 5'd1;
    localparam logic [OUT_CMD_W-1:0] OUT_ANSWER = 5'd3;
    localparam logic [OUT_CMD_W-1:0] OUT_HANGUP = 5'd4;
    localparam logic [OUT_CMD_W-1:0] OUT_REJECT = 5'd5;
    localparam logic [OUT_CMD_W-1:0] OUT_HOLD   = 5'd7;
    localparam logic [OUT_CMD_W-1:0] OUT_RESUME = 5'd8;

endpackage

// File: rtl/multi_line_call_ctrl_fifo.sv
// Four-entry outbound command queue: up to two writes and one read per cycle.
// The writer is responsible for never exceeding free_cnt.
module call_cmd_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   wr_cnt,
    input  logic [W-1:0] wr_data0,
    input  logic [W-1:0] wr_data1,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [2:0]   free_cnt
);

    localparam int DEPTH = 4;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [2:0]   count_q, count_d;
    logic         pop;

    always_comb begin
        mem_d = mem_q;
        pop = rd_en && (count_q != 3'd0);
        if (wr_cnt != 2'd0) mem_d[wr_ptr_q] = wr_data0;
        if (wr_cnt == 2'd2) mem_d[wr_ptr_q + 2'd1] = wr_data1;
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        wr_ptr_d = wr_ptr_q + wr_cnt;
        count_d  = count_q + {1'b0, wr_cnt} - {2'b00, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_valid = (count_q != 3'd0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign free_cnt = 3'(DEPTH) - count_q;

endmodule

// File: rtl/multi_line_call_ctrl.sv
// Multi-line call controller: per-line call state machines driven by user
// keys, inbound protocol events and ring timeouts, feeding a command queue.
module multi_line_call_ctrl
    import multi_line_call_ctrl_pkg::*;
#(
    parameter int NUM_LINES    = 2,
    parameter int ADDR_W       = 8,
    parameter int RING_TIMEOUT = 1_000_000,
    localparam int LW          = $clog2(NUM_LINES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enter,
    input  logic                         back,
    input  logic                         up,
    input  logic                         down,
    input  logic [ADDR_W-1:0]            dial_num,
    input  logic                         inc_valid,
    input  logic [LW-1:0]                inc_line,
    input  logic [3:0]                   inc_command,
    input  logic [ADDR_W-1:0]            inc_address,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [4:0]                   command,
    output logic [LW-1:0]                cmd_line,
    output logic [ADDR_W-1:0]            cmd_address,
    output logic [LW-1:0]                focus_line,
    output logic [STATE_W*NUM_LINES-1:0] line_state,
    output logic [ADDR_W-1:0]            caller_addr,
    output logic                         proto_err
);

    localparam int TW = $clog2(RING_TIMEOUT + 1);
    localparam int EW = OUT_CMD_W + LW + ADDR_W;
    localparam logic [LW-1:0] LAST = LW'(NUM_LINES - 1);

    line_state_e       state_q [NUM_LINES];
    line_state_e       state_d [NUM_LINES];
    logic [TW-1:0]     timer_q [NUM_LINES];
    logic [TW-1:0]     timer_d [NUM_LINES];
    logic [ADDR_W-1:0] caddr_q [NUM_LINES];
    logic [ADDR_W-1:0] caddr_d [NUM_LINES];
    logic [LW-1:0]     focus_q, focus_d;
    logic              proto_err_q, proto_err_d;

    logic [1:0]           n_wr, room_lim, need;
    logic [EW-1:0]        wr_data [2];
    logic [2:0]           fifo_free;
    logic                 fifo_valid;
    logic [EW-1:0]        fifo_head;
    logic                 user_go, user_hold, bsy_any;
    logic [LW-1:0]        bsy_idx;
    logic [OUT_CMD_W-1:0] u_cmd;
    logic [ADDR_W-1:0]    u_addr;
    line_state_e          u_ns;

    function automatic logic [EW-1:0] pack_cmd(input logic [OUT_CMD_W-1:0] c,
                                               input logic [LW-1:0] l,
                                               input logic [ADDR_W-1:0] a);
        return {c, l, a};
    endfunction

    function automatic logic is_ringing(input line_state_e s);
        return (s == ST_INCOMING) || (s == ST_OUTGOING);
    endfunction

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        caddr_d     = caddr_q;
        focus_d     = focus_q;
        proto_err_d = 1'b0;
        n_wr        = 2'd0;
        wr_data[0]  = '0;
        wr_data[1]  = '0;
        room_lim    = (fifo_free >= 3'd2) ? 2'd2 : fifo_free[1:0];
        need        = 2'd0;
        user_go     = 1'b0;
        user_hold   = 1'b0;
        bsy_any     = 1'b0;
        bsy_idx     = '0;
        u_cmd       = OUT_CALL;
        u_addr      = '0;
        u_ns        = ST_IDLE;

        if (up)        focus_d = (focus_q == LAST) ? '0 : focus_q + LW'(1);
        else if (down) focus_d = (focus_q == '0) ? LAST : focus_q - LW'(1);

        // Inbound events always apply; they are evaluated first so that
        // user actions see the post-event line states.
        if (inc_valid) begin
            if (int'(inc_line) >= NUM_LINES) begin
                proto_err_d = 1'b1;
            end else begin
                case (inc_command)
                    IN_INCOMING: begin
                        if (state_q[inc_line] == ST_IDLE) begin
                            state_d[inc_line] = ST_INCOMING;
                            caddr_d[inc_line] = inc_address;
                        end else proto_err_d = 1'b1;
                    end
                    IN_CONNECTED: begin
                        if (state_q[inc_line] == ST_OUTGOING) begin
                            for (int i = 0; i < NUM_LINES; i++) begin
                                if (LW'(i) != inc_line && state_q[i] == ST_BUSY) begin
                                    state_d[i] = ST_HOLD;
                                    if (n_wr < room_lim) begin
                                        wr_data[n_wr[0]] = pack_cmd(OUT_HOLD, LW'(i), caddr_q[i]);
                                        n_wr = n_wr + 2'd1;
                                    end
                                end
                            end
                            state_d[inc_line] = ST_BUSY;
                        end else proto_err_d = 1'b1;
                    end
                    IN_ENDED: begin
                        if (state_q[inc_line] != ST_IDLE) state_d[inc_line] = ST_IDLE;
                        else proto_err_d = 1'b1;
                    end
                    default: proto_err_d = 1'b1;
                endcase
            end
        end

        if ((enter || back) && !(inc_valid && inc_line == focus_q)) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (LW'(i) != focus_q && state_d[i] == ST_BUSY) begin
                    bsy_any = 1'b1;
                    bsy_idx = LW'(i);
                end
            end
            u_addr = caddr_d[focus_q];
            case (state_d[focus_q])
                ST_IDLE: if (enter) begin
                    user_go = 1'b1; u_cmd = OUT_CALL; u_addr = dial_num; u_ns = ST_OUTGOING;
                end
                ST_INCOMING: begin
                    user_go = 1'b1;
                    if (enter) begin
                        u_cmd = OUT_ANSWER; u_ns = ST_BUSY; user_hold = bsy_any;
                    end else begin
                        u_cmd = OUT_REJECT; u_ns = ST_IDLE;
                    end
                end
                ST_BUSY: if (enter) begin
                    user_go = 1'b1; u_cmd = OUT_HANGUP; u_ns = ST_ENDING;
                end
                ST_HOLD: begin
                    user_go = 1'b1;
                    if (enter) begin
                        u_cmd = OUT_RESUME; u_ns = ST_BUSY; user_hold = bsy_any;
                    end else begin
                        u_cmd = OUT_HANGUP; u_ns = ST_ENDING;
                    end
                end
                ST_OUTGOING: if (back) begin
                    user_go = 1'b1; u_cmd = OUT_HANGUP; u_ns = ST_ENDING;
                end
                default: ;
            endcase
            need = user_hold ? 2'd2 : 2'd1;
            if (user_go && ({1'b0, n_wr} + {1'b0, need} <= {1'b0, room_lim})) begin
                if (user_hold) begin
                    state_d[bsy_idx] = ST_HOLD;
                    wr_data[n_wr[0]] = pack_cmd(OUT_HOLD, bsy_idx, caddr_d[bsy_idx]);
                    n_wr = n_wr + 2'd1;
                end
                state_d[focus_q] = u_ns;
                wr_data[n_wr[0]] = pack_cmd(u_cmd, focus_q, u_addr);
                n_wr = n_wr + 2'd1;
            end
        end

        // Expired timers only fire on lines nothing else touched this cycle.
        for (int i = 0; i < NUM_LINES; i++) begin
            if (timer_q[i] >= TW'(RING_TIMEOUT) && state_d[i] == state_q[i] &&
                is_ringing(state_q[i]) && n_wr < room_lim) begin
                if (state_q[i] == ST_INCOMING) begin
                    state_d[i] = ST_IDLE;
                    wr_data[n_wr[0]] = pack_cmd(OUT_REJECT, LW'(i), caddr_q[i]);
                end else begin
                    state_d[i] = ST_ENDING;
                    wr_data[n_wr[0]] = pack_cmd(OUT_HANGUP, LW'(i), caddr_q[i]);
                end
                n_wr = n_wr + 2'd1;
            end
        end

        for (int i = 0; i < NUM_LINES; i++) begin
            if (state_d[i] != state_q[i] || !is_ringing(state_q[i])) timer_d[i] = '0;
            else if (timer_q[i] < TW'(RING_TIMEOUT)) timer_d[i] = timer_q[i] + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
                caddr_q[i] <= '0;
            end
            focus_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            caddr_q     <= caddr_d;
            focus_q     <= focus_d;
            proto_err_q <= proto_err_d;
        end
    end

    call_cmd_fifo #(.W(EW)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_cnt   (n_wr),
        .wr_data0 (wr_data[0]),
        .wr_data1 (wr_data[1]),
        .rd_en    (cmd_valid && cmd_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_head),
        .free_cnt (fifo_free)
    );

    always_comb begin
        line_state = '0;
        for (int i = 0; i < NUM_LINES; i++) line_state[STATE_W*i +: STATE_W] = state_q[i];
    end

    // Command fields read as zero whenever nothing is queued.
    assign cmd_valid = fifo_valid;
    assign {command, cmd_line, cmd_address} = fifo_valid ? fifo_head : '0;
    assign focus_line  = focus_q;
    assign caller_addr = caddr_q[focus_q];
    assign proto_err   = proto_err_q;

endmodule

// File: doc/multi_line_call_ctrl.md
MULTI_LINE_CALL_CTRL -- requirements
Module: multi_line_call_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 2: number of independent call lines; legal range 2..8.
REQ-002 Parameter ADDR_W, default 8: phone-number/address width.
REQ-003 Parameter RING_TIMEOUT, default 1_000_000: cycles an unanswered INCOMING or unconnected OUTGOING line waits before timeout.
REQ-004 Derived LW = $clog2(NUM_LINES): line-index width.
REQ-005 clk  in  1  system clock; all logic is on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enter, back, up, down  in  1 each  debounced one-cycle user pulses.
REQ-008 dial_num  in  ADDR_W  number to call, sampled on enter.
REQ-009 inc_valid  in  1  inbound event strobe from the application layer.
REQ-010 inc_line  in  LW  line index of the inbound event.
REQ-011 inc_command  in  4  inbound event code: 0 ENDED, 2 CONNECTED, 6 INCOMING.
REQ-012 inc_address  in  ADDR_W  caller address for INCOMING.
REQ-013 cmd_valid / cmd_ready  out / in  1 / 1  outbound command handshake.
REQ-014 command  out  5  outbound code: 1 CALL, 3 ANSWER, 4 HANGUP, 5 REJECT, 7 HOLD, 8 RESUME.
REQ-015 cmd_line  out  LW; cmd_address  out  ADDR_W  target line and address of the head command.
REQ-016 focus_line  out  LW  user-selected line.
REQ-017 line_state  out  3*NUM_LINES  packed per-line state, line 0 in the LSBs.
REQ-018 caller_addr  out  ADDR_W  last INCOMING address on focus_line.
REQ-019 proto_err  out  1  one-cycle pulse on an illegal inbound event.

Function
REQ-020 Per-line states: IDLE=0, OUTGOING=2, INCOMING=3, BUSY=4, HOLD=5, ENDING=6.
REQ-021 up/down move focus_line by ±1 modulo NUM_LINES (wrap-around both directions).
REQ-022 enter on focus line: IDLE -> queue CALL(dial_num), go OUTGOING; INCOMING -> queue ANSWER, go BUSY; BUSY -> queue HANGUP, go ENDING; HOLD -> queue RESUME, go BUSY.
REQ-023 back on focus line: INCOMING -> queue REJECT, go IDLE; OUTGOING or HOLD -> queue HANGUP, go ENDING; other states: no action.
REQ-024 At most one line is BUSY; an ANSWER or RESUME while another line is BUSY first queues HOLD for that line (state HOLD), then the ANSWER/RESUME, both in the same cycle.
REQ-025 A user action is accepted only if the command FIFO has room for every command it generates; otherwise it is dropped and no state changes.
REQ-026 Inbound: INCOMING on IDLE -> INCOMING and latch address; CONNECTED on OUTGOING -> BUSY (holding any other BUSY line via queued HOLD); ENDED on any non-IDLE -> IDLE.
REQ-027 Any other inbound code/state combination leaves state unchanged and pulses proto_err the next cycle.
REQ-028 Inbound events are never dropped; an inbound event and a user action on the same line in the same cycle: inbound applies, user action dropped.
REQ-029 Per-line timer runs in INCOMING and OUTGOING and clears on entry or exit; at RING_TIMEOUT it forces a REJECT (INCOMING -> IDLE) or a HANGUP (OUTGOING -> ENDING), bypassing REQ-025 only if the FIFO has room, otherwise retrying each cycle.
REQ-030 Commands are issued in FIFO order; transfer occurs on cmd_valid && cmd_ready; command, cmd_line and cmd_address hold stable while cmd_valid && !cmd_ready.
REQ-031 Latency: state update and FIFO write one cycle after the triggering pulse; cmd_valid high no earlier than the following cycle.

Reset
REQ-032 On reset low: all lines IDLE, timers 0, focus_line 0, caller_addr 0, FIFO empty, cmd_valid 0, command 0, cmd_line 0, cmd_address 0, proto_err 0, effective immediately.
REQ-033 Reset mid-call discards queued commands; no HANGUP is emitted.

Structure
REQ-034 A shared package holds the line-state encodings, the inbound and outbound command codes, and the state-field width 3.
REQ-035 The outbound queue is sub-module call_cmd_fifo: 4 entries, with writes of 0, 1 or 2 entries per cycle, one read per cycle, and a free-slot count output.

Verification
REQ-036 NUM_LINES=2, RING_TIMEOUT=16: enter with dial_num=0x04 on line 0 -> CALL/line0/0x04; then CONNECTED line0 -> line_state[2:0]=4.
REQ-037 Line 0 BUSY, INCOMING line1 addr 0x2A, down, enter -> HOLD/line0, then ANSWER/line1 in order; line0=5, line1=4, caller_addr=0x2A.
REQ-038 INCOMING line1, no input for 16 cycles -> REJECT/line1, line1=0.
REQ-039 cmd_ready=0 with 4 queued commands, enter on IDLE line -> action dropped, line remains 0, head command stable.
REQ-040 CONNECTED on IDLE line -> proto_err pulse, no state change; up at focus 0 -> focus_line=1.
REQ-041 Reset low while line0 BUSY with 2 commands queued -> all outputs at reset values, no command transferred.
